// File: rtl/seg_display_ctrl_pkg.sv
// rtl/seg_display_ctrl_pkg.sv - shared types, glyph table and constants for seg_display_ctrl
//
// Package seg_pkg:
//   state_e     : conversion FSM states (IDLE, CONV)
//   SEG_OFF     : active-high segment pattern with every segment dark
//   SEG_MINUS   : active-high segment pattern for '-' (segment g only)
//   glyph()     : nibble -> active-high segments, bit 6 = a ... bit 0 = g
//   pow10()     : 10^n as a 64-bit constant, used for the decimal overflow bound
package seg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  localparam logic [6:0] SEG_OFF   = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b0000001;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// rtl/seg_display_ctrl_if.sv - valid/ready load port bundle for seg_display_ctrl
//
// Signals:
//   load_valid : load request (master -> slave)
//   load_ready : controller can accept a load (slave -> master)
//   load_data  : unsigned value to display, DATA_W bits
//   load_dec   : 1 = decimal mode, 0 = hex mode
//   load_blank : 1 = blank leading zeros
//   load_dp    : decimal point mask, bit i belongs to digit i
interface seg_load_if #(
  parameter int DATA_W = 32,
  parameter int DIGITS = 8
);

  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic              load_dec;
  logic              load_blank;
  logic [DIGITS-1:0] load_dp;

  modport master (
    output load_valid,
    output load_data,
    output load_dec,
    output load_blank,
    output load_dp,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_dec,
    input  load_blank,
    input  load_dp,
    output load_ready
  );

endinterface

// File: rtl/seg_display_ctrl_bin2bcd.sv
// rtl/seg_display_ctrl_bin2bcd.sv - iterative double-dabble binary to BCD converter
//
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start_i : load data_i and perform the first shift on this edge
//   data_i  : unsigned binary input, DATA_W bits
//   done_o  : high during the cycle whose closing edge completes the result hand-off
//   bcd_o   : DIGITS+1 BCD nibbles, valid while done_o is high
module bin2bcd_seq #(
  parameter int DATA_W = 32,
  parameter int DIGITS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [DATA_W-1:0]         data_i,
  output logic                      done_o,
  output logic [4*(DIGITS+1)-1:0]   bcd_o
);

  localparam int BCD_W = 4 * (DIGITS + 1);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next bit.
  // Bits leaving the top nibble are dropped; the caller detects overflow separately.
  function automatic logic [BCD_W-1:0] dabble(input logic [BCD_W-1:0] b, input logic bit_in);
    logic [BCD_W-1:0] t;
    t = b;
    for (int i = 0; i < DIGITS + 1; i++) begin
      if (t[4*i +: 4] >= 4'd5) begin
        t[4*i +: 4] = t[4*i +: 4] + 4'd3;
      end
    end
    return {t[BCD_W-2:0], bit_in};
  endfunction

  // The start edge already performs shift #1, so DATA_W shifts are complete
  // when cnt_q reaches DATA_W and the commit lands DATA_W edges after start.
  assign done_o = busy_q && (cnt_q == CNT_W'(DATA_W));
  assign bcd_o  = bcd_q;

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      bcd_d  = dabble('0, data_i[DATA_W-1]);
      bin_d  = data_i << 1;
      cnt_d  = CNT_W'(1);
      busy_d = 1'b1;
    end else if (done_o) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      bcd_d = dabble(bcd_q, bin_q[DATA_W-1]);
      bin_d = bin_q << 1;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - multiplexed seven-segment display controller, hex or decimal
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   load : seg_load_if.slave load port (valid/ready, data, dec, blank, dp mask)
//   a2g  : segments, bit 6 = a ... bit 0 = g, registered
//   dp   : decimal point segment, registered
//   an   : digit enables, an[i] = digit i, registered
//   ovf  : committed decimal value did not fit in DIGITS digits
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int DATA_W         = 32,
  parameter int DIV_W          = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  seg_load_if.slave         load,
  output logic [6:0]        a2g,
  output logic              dp,
  output logic [DIGITS-1:0] an,
  output logic              ovf
);

  localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int               BCD_W    = 4 * (DIGITS + 1);
  localparam logic [63:0]      DEC_LIM  = pow10(DIGITS);
  localparam logic [6:0]       SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic             DP_IDLE  = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_IDLE = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  state_e              state_q;
  logic [4*DIGITS-1:0] val_q;
  logic                blank_q;
  logic [DIGITS-1:0]   dpm_q;
  logic                ovf_q;
  logic                pend_blank_q;
  logic [DIGITS-1:0]   pend_dp_q;
  logic                pend_big_q;

  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    scan_q, scan_d;
  logic [6:0]          a2g_q, a2g_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                load_ready;
  logic                accept;
  logic                conv_start;
  logic                conv_done;
  logic [BCD_W-1:0]    conv_bcd;
  logic [63:0]         data_wide;
  logic [DIGITS-1:0]   blanked;

  assign load_ready      = (state_q == IDLE);
  assign load.load_ready = load_ready;
  assign accept          = load.load_valid && load_ready;
  assign conv_start      = accept && load.load_dec;
  assign data_wide       = 64'(load.load_data);

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst),
    .start_i (conv_start),
    .data_i  (load.load_data),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  // Committed state changes only on a hex accept or on the conversion's final
  // edge, so the scanner never sees a half-updated value. Blank and dp settings
  // of a decimal load are held aside until that final edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      val_q        <= '0;
      blank_q      <= 1'b0;
      dpm_q        <= '0;
      ovf_q        <= 1'b0;
      pend_blank_q <= 1'b0;
      pend_dp_q    <= '0;
      pend_big_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (load.load_dec) begin
              state_q      <= CONV;
              pend_blank_q <= load.load_blank;
              pend_dp_q    <= load.load_dp;
              // The BCD register drops digits beyond DIGITS+1, so large values
              // are caught by a direct magnitude compare at accept time.
              pend_big_q   <= (data_wide >= DEC_LIM);
            end else begin
              val_q   <= data_wide[4*DIGITS-1:0];
              blank_q <= load.load_blank;
              dpm_q   <= load.load_dp;
              ovf_q   <= 1'b0;
            end
          end
        end
        CONV: begin
          if (conv_done) begin
            state_q <= IDLE;
            val_q   <= conv_bcd[4*DIGITS-1:0];
            ovf_q   <= pend_big_q || (conv_bcd[BCD_W-1 -: 4] != 4'd0);
            blank_q <= pend_blank_q;
            dpm_q   <= pend_dp_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Digit i is blanked when it and every digit above it are zero; digit 0 never is.
  always_comb begin
    logic z;
    z       = 1'b1;
    blanked = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z          = z && (val_q[4*i +: 4] == 4'd0);
      blanked[i] = z && (i != 0) && blank_q && !ovf_q;
    end
  end

  // Scan runs freely from the most significant digit downward; loads never touch it.
  always_comb begin
    div_d  = div_q + DIV_W'(1);
    scan_d = scan_q;
    if (div_q == {DIV_W{1'b1}}) begin
      scan_d = (scan_q == IDX_W'(0)) ? IDX_W'(DIGITS - 1) : scan_q - IDX_W'(1);
    end
  end

  always_comb begin
    logic [6:0]        seg_act;
    logic              dp_act;
    logic [DIGITS-1:0] an_act;
    logic              blk;
    blk = blanked[scan_q];
    if (ovf_q) begin
      seg_act = SEG_MINUS;
    end else if (blk) begin
      seg_act = SEG_OFF;
    end else begin
      seg_act = glyph(val_q[4*scan_q +: 4]);
    end
    dp_act = dpm_q[scan_q] && !ovf_q;
    an_act = blk ? '0 : (DIGITS'(1) << scan_q);
    a2g_d  = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
    dp_d   = SEG_ACTIVE_LOW ? ~dp_act : dp_act;
    an_d   = AN_ACTIVE_LOW ? ~an_act : an_act;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      scan_q <= IDX_W'(DIGITS - 1);
      a2g_q  <= SEG_IDLE;
      dp_q   <= DP_IDLE;
      an_q   <= AN_IDLE;
    end else begin
      div_q  <= div_d;
      scan_q <= scan_d;
      a2g_q  <= a2g_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
    end
  end

  assign a2g = a2g_q;
  assign dp  = dp_q;
  assign an  = an_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb/tb_seg_display_ctrl.sv - scoreboard testbench for seg_display_ctrl
module tb_seg_display_ctrl;

  logic       clk;
  logic       rst;
  logic [6:0] a2g;
  logic       dp;
  logic [7:0] an;
  logic       ovf;

  seg_load_if #(.DATA_W(32), .DIGITS(8)) lif ();

  seg_display_ctrl #(
    .DIGITS         (8),
    .DATA_W         (32),
    .DIV_W          (2),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .load (lif),
    .a2g  (a2g),
    .dp   (dp),
    .an   (an),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] an;
    logic [6:0] a2g;
    logic       dp;
    logic       ovf;
    logic       chk_seg;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   mon_d;
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Active-low glyphs, hand-derived from the board's segment table.
  function automatic logic [6:0] seg_of(input byte c);
    case (c)
      "0":     return 7'b0000001;
      "1":     return 7'b1001111;
      "2":     return 7'b0010010;
      "3":     return 7'b0000110;
      "4":     return 7'b1001100;
      "5":     return 7'b0100100;
      "6":     return 7'b0100000;
      "7":     return 7'b0001111;
      "8":     return 7'b0000000;
      "9":     return 7'b0000100;
      "A":     return 7'b0001000;
      "b":     return 7'b1100000;
      "C":     return 7'b0110001;
      "d":     return 7'b1000010;
      "E":     return 7'b0110000;
      "F":     return 7'b0111000;
      "-":     return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction

  // Monitor: tracks the scan position from reset release (4 clocks per digit,
  // digit 7 first) and checks the queued expectation at the start of each dwell.
  always @(negedge clk) begin
    if (!rst) begin
      cyc = 0;
    end else begin
      cyc = cyc + 1;
      if (((cyc - 1) % 4 == 0) && (sb_q.size() > 0)) begin
        mon_d = 7 - (((cyc - 1) / 4) % 8);
        if (sb_q[0].idx == mon_d) begin
          mon_e = sb_q.pop_front();
          chk($sformatf("an_d%0d", mon_e.idx), 32'(an), 32'(mon_e.an));
          if (mon_e.chk_seg) chk($sformatf("a2g_d%0d", mon_e.idx), 32'(a2g), 32'(mon_e.a2g));
          chk($sformatf("dp_d%0d", mon_e.idx), 32'(dp), 32'(mon_e.dp));
          chk($sformatf("ovf_d%0d", mon_e.idx), 32'(ovf), 32'(mon_e.ovf));
        end
      end
    end
  end

  // s[0] is digit 7 ... s[7] is digit 0; ' ' marks a blanked digit.
  task automatic expect_display(input string s, input logic [7:0] dpm, input logic xovf);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.idx     = 7 - k;
      e.an      = 8'hFF;
      e.chk_seg = (s[k] != " ");
      if (e.chk_seg) e.an[e.idx] = 1'b0;
      e.a2g     = seg_of(s[k]);
      e.dp      = ~dpm[e.idx];
      e.ovf     = xovf;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(negedge clk);
    chk({"drain_", name}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic drive(input logic [31:0] d, input logic dec, input logic blk, input logic [7:0] dpm);
    int n;
    @(negedge clk);
    lif.load_valid = 1'b1;
    lif.load_data  = d;
    lif.load_dec   = dec;
    lif.load_blank = blk;
    lif.load_dp    = dpm;
    n = 0;
    while (!lif.load_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1 lif.load_valid = 1'b0;
  endtask

  task automatic hex_load(input logic [31:0] d, input logic blk, input logic [7:0] dpm);
    drive(d, 1'b0, blk, dpm);
    @(negedge clk);
    chk("hex_ready", 32'(lif.load_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // hold: display expected while converting ("" = not checked); pulse: try a load mid-conversion.
  task automatic dec_load(input logic [31:0] d, input logic blk, input logic [7:0] dpm,
                          input string hold, input bit pulse, input string name);
    int cnt;
    int bad;
    drive(d, 1'b1, blk, dpm);
    cnt = 0;
    bad = 0;
    @(negedge clk);
    while (!lif.load_ready && cnt < 100) begin
      cnt++;
      if (hold != "" && an != 8'hFF) begin
        for (int k = 0; k < 8; k++) begin
          if (an[k] == 1'b0 && a2g !== seg_of(hold[7-k])) bad++;
        end
      end
      if (pulse && cnt == 5) begin
        lif.load_valid = 1'b1;
        lif.load_data  = 32'hFFFF_FFFF;
        lif.load_dec   = 1'b0;
      end
      if (pulse && cnt == 8) lif.load_valid = 1'b0;
      @(negedge clk);
    end
    lif.load_valid = 1'b0;
    chk({"busy_cycles_", name}, 32'(cnt), 32'd32);
    if (hold != "") chk({"hold_", name}, 32'(bad), 32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst            = 1'b0;
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    lif.load_dec   = 1'b0;
    lif.load_blank = 1'b0;
    lif.load_dp    = '0;

    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_a2g", 32'(a2g), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_ready", 32'(lif.load_ready), 32'd1);
    chk("rst_ovf", 32'(ovf), 32'd0);
    expect_display("00000000", 8'h00, 1'b0);
    #2 rst = 1'b1;
    wait_drain("reset");

    hex_load(32'h1234ABCD, 1'b0, 8'h00);
    expect_display("1234AbCd", 8'h00, 1'b0);
    wait_drain("hex");

    dec_load(32'd12345678, 1'b1, 8'h00, "1234AbCd", 1'b1, "dec");
    expect_display("12345678", 8'h00, 1'b0);
    wait_drain("dec");

    dec_load(32'd42, 1'b1, 8'h02, "", 1'b0, "d42");
    expect_display("      42", 8'h02, 1'b0);
    wait_drain("d42");

    hex_load(32'h0000_00A0, 1'b1, 8'h80);
    expect_display("      A0", 8'h80, 1'b0);
    wait_drain("hexblank");

    dec_load(32'd123456789, 1'b1, 8'hFF, "", 1'b0, "ovf9");
    expect_display("--------", 8'h00, 1'b1);
    wait_drain("ovf9");

    dec_load(32'd99999999, 1'b1, 8'h00, "", 1'b0, "max");
    expect_display("99999999", 8'h00, 1'b0);
    wait_drain("max");

    dec_load(32'hFFFF_FFFF, 1'b0, 8'h00, "", 1'b0, "ovfbig");
    expect_display("--------", 8'h00, 1'b1);
    wait_drain("ovfbig");

    dec_load(32'd0, 1'b1, 8'h00, "", 1'b0, "zero");
    expect_display("       0", 8'h00, 1'b0);
    wait_drain("zero");

    // Reset at conversion clock 10: partial result must vanish.
    drive(32'd12345678, 1'b1, 1'b1, 8'hFF);
    repeat (10) @(negedge clk);
    chk("midconv_busy", 32'(lif.load_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_ready", 32'(lif.load_ready), 32'd1);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    chk("midrst_an", 32'(an), 32'hFF);
    expect_display("00000000", 8'h00, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    wait_drain("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
